// File: rtl/uop_and2_tester.sv
// Stimulus/response checker for a 2-input AND/NAND gate block.
// Sweeps {x,y} = 00..11, samples z/notz after a settle time, logs errors.
module uop_and2_tester #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic             z,
  input  logic             notz,
  output logic             x,
  output logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [1:0]       fail_vec
);

  localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    FIN
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             exp_z;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  always_comb begin
    exp_z    = x & y;
    mismatch = (z != exp_z) || (notz != ~exp_z);
    err_next = err_count;
    if (mismatch && (err_count != '1))
      err_next = err_count + ERR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      x          <= 1'b0;
      y          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= 2'b00;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= SWEEP;
            cnt        <= '0;
            {x, y}     <= 2'b00;
            busy       <= 1'b1;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= 2'b00;
          end
        end
        SWEEP: begin
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            err_count <= err_next;
            if (mismatch && !fail_valid) begin
              fail_valid <= 1'b1;
              fail_vec   <= {x, y};
            end
            // last vector keeps driving 11 through the done cycle
            if ({x, y} == 2'b11) begin
              state <= FIN;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end else begin
              {x, y} <= {x, y} + 2'b01;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FIN: begin
          cnt    <= '0;
          {x, y} <= 2'b00;
          if (continuous) begin
            state <= SWEEP;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
